mem_port_arbiter: RTL and testbench

Arbitrates the processor's single-ported unified memory between instruction fetch and load/store data access. Sits between the fetch stage / PC logic and the memory on one side, and the load/store path that the control unit's MemRead/MemWrite drive on the other. Grants at most one access per cycle, returns read data one cycle later, and stalls the PC whenever a fetch is not granted.

---
 rtl/femto_pkg.sv | 15 +
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_arb_starve_cnt.sv | 33 +++
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/femto_pkg.sv
// Shared types and default widths for the unified-memory port arbiter.
// The response state records which requester owns the read data arriving next cycle.
package femto_pkg;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned STARVE_LIM_DEF = 4;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_IF   = 2'd1,
    RSP_D    = 2'd2
  } rsp_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-port signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding core and memory.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_pc;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata, stall_pc
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata, stall_pc
  );

endinterface

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of consecutive cycles a fetch has been denied the memory port.
// at_limit hands priority to fetch; the count never wraps.
module mem_arb_starve_cnt #(
  parameter int unsigned LIM = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);
  localparam int unsigned CNT_W = $clog2(LIM + 1);
  localparam logic [CNT_W-1:0] LIM_C = CNT_W'(LIM);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // Counter register: clear wins over increment, holds at the limit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != LIM_C)) begin
      r_cnt <= r_cnt + ONE_C;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign at_limit = (r_cnt == LIM_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// Data wins unless fetch has starved; read data returns one cycle after its grant.
module mem_port_arbiter
  import femto_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_LIM = STARVE_LIM_DEF
) (
  input logic              clk,
  input logic              rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic       w_if_gnt;
  logic       w_d_gnt;
  logic       w_at_limit;
  logic       w_starve_inc;
  logic       w_starve_clr;
  logic       w_if_rvalid;
  logic       w_d_rvalid;
  rsp_state_e r_state;
  rsp_state_e w_state_nxt;

  // Grant selection: one winner per cycle, nothing while reset is held.
  always_comb begin
    w_if_gnt = 1'b0;
    w_d_gnt  = 1'b0;
    if (!rst_n) begin
      w_if_gnt = 1'b0;
      w_d_gnt  = 1'b0;
    end else if (bus.if_req && (!bus.d_req || w_at_limit)) begin
      w_if_gnt = 1'b1;
    end else if (bus.d_req) begin
      w_d_gnt = 1'b1;
    end else begin
      w_if_gnt = 1'b0;
      w_d_gnt  = 1'b0;
    end
  end

  assign w_starve_inc = bus.if_req & ~w_if_gnt;
  assign w_starve_clr = w_if_gnt | ~bus.if_req;

  mem_arb_starve_cnt #(
    .LIM (STARVE_LIM)
  ) u_starve_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (w_starve_inc),
    .clr      (w_starve_clr),
    .at_limit (w_at_limit)
  );

  // Memory port mux: the granted requester drives address, enables and data.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = {BE_W{1'b0}};
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};
    if (w_if_gnt) begin
      bus.mem_en   = 1'b1;
      bus.mem_be   = {BE_W{1'b1}};
      bus.mem_addr = bus.if_addr;
    end else if (w_d_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.d_we;
      bus.mem_be    = bus.d_be;
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end else begin
      bus.mem_en = 1'b0;
    end
  end

  // Response state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RSP_NONE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next response owner: stores complete at grant and leave nothing outstanding.
  always_comb begin
    w_state_nxt = RSP_NONE;
    if (w_if_gnt) begin
      w_state_nxt = RSP_IF;
    end else if (w_d_gnt && !bus.d_we) begin
      w_state_nxt = RSP_D;
    end else begin
      w_state_nxt = RSP_NONE;
    end
  end

  // Response valids; a reset arriving under an outstanding read discards it.
  always_comb begin
    w_if_rvalid = 1'b0;
    w_d_rvalid  = 1'b0;
    case (r_state)
      RSP_IF:  w_if_rvalid = rst_n;
      RSP_D:   w_d_rvalid  = rst_n;
      default: begin
        w_if_rvalid = 1'b0;
        w_d_rvalid  = 1'b0;
      end
    endcase
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.if_rvalid = w_if_rvalid;
  assign bus.d_rvalid  = w_d_rvalid;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;
  assign bus.stall_pc  = bus.if_req & ~w_if_gnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, all checked
// against a cycle-level reference model with its own copy of memory contents.
module tb_mem_port_arbiter;
  import femto_pkg::*;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int          LIM = 4;
  localparam int          MW  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] seed_word(input int i);
    return 32'h1357_9BDF ^ (i * 32'h0101_0103);
  endfunction

  // Behavioural memory device: read data appears one cycle after a read enable.
  logic [31:0] dev_mem [MW];
  logic [31:0] dev_q = 32'h0;
  logic        dev_fill = 1'b1;
  always @(posedge clk) begin
    if (dev_fill) begin
      for (int i = 0; i < MW; i++) dev_mem[i] <= seed_word(i);
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) dev_mem[bus.mem_addr[5:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        dev_q <= dev_mem[bus.mem_addr[5:2]];
      end
    end
  end
  assign bus.mem_rdata = dev_q;

  // Reference model state.
  logic [31:0] ref_mem [MW];
  int          starve = 0;
  int          pend   = 0;   // 0 nothing, 1 fetch data due, 2 load data due
  logic [31:0] pend_data = 32'h0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check, advance the model.
  task automatic step(input logic rv, input logic ifr, input logic [31:0] ifa,
                      input logic dr, input logic dwe, input logic [3:0] dbe,
                      input logic [31:0] da, input logic [31:0] dwd,
                      output logic gi, output logic gd);
    logic eiv, edv;
    rst_n       = rv;
    bus.if_req  = ifr;
    bus.if_addr = ifa;
    bus.d_req   = dr;
    bus.d_we    = dwe;
    bus.d_be    = dbe;
    bus.d_addr  = da;
    bus.d_wdata = dwd;
    #1;
    eiv = rv && (pend == 1);
    edv = rv && (pend == 2);
    gi  = rv && ifr && (!dr || starve >= LIM);
    gd  = rv && dr && !gi;
    check_eq("if_gnt",    bus.if_gnt,    gi);
    check_eq("d_gnt",     bus.d_gnt,     gd);
    check_eq("stall_pc",  bus.stall_pc,  ifr && !gi);
    check_eq("mem_en",    bus.mem_en,    gi || gd);
    check_eq("mem_we",    bus.mem_we,    gd && dwe);
    check_eq("mem_be",    bus.mem_be,    gi ? 4'hF : (gd ? dbe : 4'h0));
    check_eq("mem_addr",  bus.mem_addr,  gi ? ifa : (gd ? da : 32'h0));
    check_eq("mem_wdata", bus.mem_wdata, gd ? dwd : 32'h0);
    check_eq("if_rvalid", bus.if_rvalid, eiv);
    check_eq("d_rvalid",  bus.d_rvalid,  edv);
    if (eiv) check_eq("if_rdata", bus.if_rdata, pend_data);
    if (edv) check_eq("d_rdata",  bus.d_rdata,  pend_data);
    if (!rv) begin
      starve = 0;
      pend   = 0;
    end else begin
      starve = (ifr && !gi) ? ((starve < LIM) ? starve + 1 : LIM) : 0;
      if (gi) begin
        pend = 1; pend_data = ref_mem[ifa[5:2]];
      end else if (gd && !dwe) begin
        pend = 2; pend_data = ref_mem[da[5:2]];
      end else begin
        pend = 0;
      end
      if (gd && dwe)
        for (int b = 0; b < 4; b++)
          if (dbe[b]) ref_mem[da[5:2]][8*b +: 8] = dwd[8*b +: 8];
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rv);
    logic gi, gd;
    step(rv, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd);
  endtask

  initial begin
    logic        gi, gd, pif, pd, we, rv;
    logic [31:0] ia, da, wd;
    logic [3:0]  be;
    for (int i = 0; i < MW; i++) ref_mem[i] = seed_word(i);
    @(negedge clk);
    idle(1'b0);
    idle(1'b0);
    dev_fill = 1'b0;
    idle(1'b0);
    idle(1'b1);

    // Lone fetch, then its data.
    step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd);
    idle(1'b1);
    // Load and fetch together: data first, fetch next cycle.
    step(1'b1, 1'b1, 32'h104, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h0, gi, gd);
    step(1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 4'hF, 32'h2000, 32'h0, gi, gd);
    idle(1'b1);
    // Partial store, then read it back.
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h3000, 32'hDEADBEEF, gi, gd);
    idle(1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h3000, 32'h0, gi, gd);
    idle(1'b1);
    // Continuous data traffic against a held fetch: starvation override.
    for (int c = 0; c < 10; c++)
      step(1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 4'hF, 32'h40 + 32'(c * 4), 32'h0, gi, gd);
    idle(1'b1);
    // Back-to-back fetches.
    for (int c = 0; c < 3; c++)
      step(1'b1, 1'b1, 32'(c * 4), 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd);
    idle(1'b1);
    idle(1'b1);
    // Reset right after a load grant discards the response.
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0, gi, gd);
    step(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0, gi, gd);
    idle(1'b1);
    idle(1'b1);

    // Random traffic: requests held until granted, addresses may move while waiting.
    pif = 1'b0; pd = 1'b0; we = 1'b0; be = 4'h0;
    ia = 32'h0; da = 32'h0; wd = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      if (!pif && $urandom_range(0, 99) < 60) begin
        pif = 1'b1; ia = $urandom & 32'hFFFF_FFFC;
      end else if (pif && $urandom_range(0, 99) < 10) begin
        ia = $urandom & 32'hFFFF_FFFC;
      end
      if (!pd && $urandom_range(0, 99) < 50) begin
        pd = 1'b1; we = 1'($urandom_range(0, 1));
        be = 4'($urandom); da = $urandom & 32'hFFFF_FFFC; wd = $urandom;
      end else if (pd && $urandom_range(0, 99) < 10) begin
        wd = $urandom;
      end
      rv = ($urandom_range(0, 99) >= 2);
      step(rv, pif, ia, pd, we, be, da, wd, gi, gd);
      if (gi) pif = 1'b0;
      if (gd) pd  = 1'b0;
    end
    idle(1'b1);
    idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
